// File: rtl/pipelined_adder.sv
// Streaming WIDTH-bit adder: one CHUNK-bit slice per stage, carry registered between stages, valid/ready flow control.
// Optional signed-overflow output `ovf` is built when PIPELINED_ADDER_OVF_EN is defined.
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef PIPELINED_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CHUNK = WIDTH / STAGES;

  logic [STAGES-1:0] valid_s;
  logic [STAGES-1:0] rdy_s;

  // A stage may load when it is empty or everything downstream of it can advance
  always_comb begin
    logic down;
    down  = out_ready;
    rdy_s = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy_s[k] = !valid_s[k] || down;
      down     = rdy_s[k];
    end
  end

  assign in_ready = rdy_s[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits still to be consumed on entry to this stage
    localparam int IW = (STAGES - k) * CHUNK;

    logic                      in_valid_s;
    logic                      in_carry_s;
    logic [IW-1:0]             in_x_s;
    logic [IW-1:0]             in_y_s;
    logic [CHUNK:0]            add_s;
    logic [(k+1)*CHUNK-1:0]    next_sum_s;
    logic                      valid_r;
    logic                      carry_r;
    logic [(k+1)*CHUNK-1:0]    sum_r;

    assign add_s = {1'b0, in_x_s[CHUNK-1:0]} + {1'b0, in_y_s[CHUNK-1:0]}
                 + {{CHUNK{1'b0}}, in_carry_s};

    if (k == 0) begin : g_src
      assign in_valid_s = in_valid;
      assign in_carry_s = cin;
      assign in_x_s     = x;
      assign in_y_s     = y;
      assign next_sum_s = add_s[CHUNK-1:0];
    end else begin : g_src
      assign in_valid_s = g_stage[k-1].valid_r;
      assign in_carry_s = g_stage[k-1].carry_r;
      assign in_x_s     = g_stage[k-1].g_ops.x_r;
      assign in_y_s     = g_stage[k-1].g_ops.y_r;
      assign next_sum_s = {add_s[CHUNK-1:0], g_stage[k-1].sum_r};
    end

    // Valid, carry and accumulated sum; data only moves when a real beat arrives
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_r <= 1'b0;
        carry_r <= 1'b0;
        sum_r   <= '0;
      end else if (rdy_s[k]) begin
        valid_r <= in_valid_s;
        if (in_valid_s) begin
          carry_r <= add_s[CHUNK];
          sum_r   <= next_sum_s;
        end
      end
    end

    assign valid_s[k] = valid_r;

    if (k < STAGES - 1) begin : g_ops
      logic [IW-CHUNK-1:0] x_r;
      logic [IW-CHUNK-1:0] y_r;

      // Unused upper operand chunks travel alongside the partial sum
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          x_r <= '0;
          y_r <= '0;
        end else if (rdy_s[k] && in_valid_s) begin
          x_r <= in_x_s[IW-1:CHUNK];
          y_r <= in_y_s[IW-1:CHUNK];
        end
      end
    end

`ifdef PIPELINED_ADDER_OVF_EN
    if (k == STAGES - 1) begin : g_ovf
      logic ovf_r;

      // Carry into the MSB is recovered as x_msb ^ y_msb ^ sum_msb
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_r <= 1'b0;
        end else if (rdy_s[k] && in_valid_s) begin
          ovf_r <= in_x_s[CHUNK-1] ^ in_y_s[CHUNK-1] ^ add_s[CHUNK-1] ^ add_s[CHUNK];
        end
      end
    end
`endif
  end

  assign out_valid = g_stage[STAGES-1].valid_r;
  assign s         = g_stage[STAGES-1].sum_r;
  assign cout      = g_stage[STAGES-1].carry_r;
`ifdef PIPELINED_ADDER_OVF_EN
  assign ovf       = g_stage[STAGES-1].g_ovf.ovf_r;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed and random streams scored against
// a queue-based arithmetic model, with latency, stall-stability, capacity and reset checks.
module tb_pipelined_adder;
  localparam int WIDTH  = 16;
  localparam int STAGES = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] x = '0;
  logic [WIDTH-1:0] y = '0;
  logic             cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] s;
  logic             cout;
`ifdef PIPELINED_ADDER_OVF_EN
  logic             ovf;
`endif

  pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout)
`ifdef PIPELINED_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             c;
    logic             o;
    int               acc;
  } exp_t;

  exp_t             q[$];
  int               tests = 0;
  int               fails = 0;
  int               cyc = 0;
  int               acc_cnt = 0;
  int               ovalid_cnt = 0;
  bit               chk_lat = 1'b0;
  logic             pv = 1'b0;
  logic             pr = 1'b0;
  logic [WIDTH-1:0] ps = '0;
  logic             pc = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic for sum/carry, signed range test for overflow
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic ci);
    exp_t          e;
    longint        u;
    longint        sa;
    longint        sb;
    longint        t;
    longint        half;
    half  = longint'(1) << (WIDTH - 1);
    u     = longint'(a) + longint'(b) + longint'(ci);
    e.sum = WIDTH'(u);
    e.c   = ((u >> WIDTH) & 64'd1) != 0;
    sa    = (longint'(a) >= half) ? longint'(a) - 2 * half : longint'(a);
    sb    = (longint'(b) >= half) ? longint'(b) - 2 * half : longint'(b);
    t     = sa + sb + longint'(ci);
    e.o   = (t > half - 1) || (t < -half);
    e.acc = cyc;
    return e;
  endfunction

  // One clock: sample before the edge, score transfers, then move past the edge
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    check("in_ready", in_ready, (q.size() < STAGES) || out_ready);
    if (pv && !pr) begin
      check("stall_valid", out_valid, 1'b1);
      check("stall_s", s, ps);
      check("stall_cout", cout, pc);
    end
    if (out_valid) ovalid_cnt++;
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("spurious_out_valid", out_valid, 1'b0);
      end else begin
        e = q.pop_front();
        check("s", s, e.sum);
        check("cout", cout, e.c);
`ifdef PIPELINED_ADDER_OVF_EN
        check("ovf", ovf, e.o);
`endif
        if (chk_lat) check("latency", cyc - e.acc, STAGES);
      end
    end
    if (in_valid && in_ready) begin
      q.push_back(model(x, y, cin));
      acc_cnt++;
    end
    pv = out_valid;
    pr = out_ready;
    ps = s;
    pc = cout;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ci);
    x = a; y = b; cin = ci; in_valid = 1'b1;
    cycle();
    while (!(q.size() > 0 && acc_cnt > 0 && in_valid && pv !== 1'bx && q[$].acc == cyc - 1)) begin
      if (cyc > 90000) break;
      cycle();
    end
    in_valid = 1'b0;
  endtask

  logic [WIDTH-1:0] sx [8] = '{16'h1234, 16'hFEDC, 16'h0000, 16'hFFFF,
                               16'h8000, 16'h0F0F, 16'h7FFF, 16'hC3A5};
  logic [WIDTH-1:0] sy [8] = '{16'hABCD, 16'hBA98, 16'h0000, 16'h0000,
                               16'h8000, 16'hF0F0, 16'h7FFF, 16'h5A3C};
  logic             sc [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_s", s, 16'h0000);
    check("rst_cout", cout, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;

    // Single beat: exact latency and one-cycle output
    chk_lat = 1'b1; out_ready = 1'b1; ovalid_cnt = 0;
    send(16'hAAAA, 16'h5555, 1'b0);
    repeat (8) cycle();
    check("single_valid_cycles", ovalid_cnt, 1);
    check("single_drained", q.size(), 0);

    // Full-length carry ripple
    send(16'hFFFF, 16'h0001, 1'b0);
    send(16'hFFFF, 16'hFFFF, 1'b1);
    repeat (6) cycle();

    // Back-to-back stream, one result per cycle
    for (int i = 0; i < 8; i++) begin
      x = sx[i]; y = sy[i]; cin = sc[i]; in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    repeat (6) cycle();
    check("stream_drained", q.size(), 0);

    // Backpressure: capacity is STAGES beats, then drain in order
    chk_lat = 1'b0; out_ready = 1'b0; acc_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      x = WIDTH'($urandom); y = WIDTH'($urandom); cin = 1'($urandom); in_valid = 1'b1;
      cycle();
    end
    check("bp_accepts", acc_cnt, STAGES);
    check("bp_in_ready_low", in_ready, 1'b0);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) cycle();
    check("bp_drained", q.size(), 0);

    // Asynchronous reset with three beats in flight
    for (int i = 0; i < 3; i++) begin
      x = WIDTH'($urandom); y = WIDTH'($urandom); cin = 1'b1; in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_s", s, 16'h0000);
    check("arst_cout", cout, 1'b0);
    check("arst_in_ready", in_ready, 1'b1);
    q.delete(); pv = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    ovalid_cnt = 0;
    repeat (8) cycle();
    check("arst_no_stale", ovalid_cnt, 0);

`ifdef PIPELINED_ADDER_OVF_EN
    chk_lat = 1'b1;
    send(16'h7FFF, 16'h0001, 1'b0);
    send(16'h7FFF, 16'h8001, 1'b0);
    repeat (6) cycle();
`endif

    // Random traffic with random backpressure
    chk_lat = 1'b0;
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      x = WIDTH'($urandom); y = WIDTH'($urandom); cin = 1'($urandom);
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      cycle();
      n++;
    end
    check("final_drain", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined binary adder with valid/ready flow control. It is the streaming successor to the team's fixed 16-bit combinational adder. Operands are split into `STAGES` equal chunks, and one chunk is added per pipeline stage, with the carry registered between stages. This lets wide adds close timing at high clock rates. It sits between operand-producing datapath blocks and downstream consumers that may apply backpressure.

## Interface
Parameters:
- `WIDTH`, 16, operand and sum width in bits; must be ≥1.
- `STAGES`, 4, pipeline depth; must divide `WIDTH`; `CHUNK = WIDTH/STAGES` bits are added per stage.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `in_valid`  in  1  operand beat present.
- `in_ready`  out  1  block can accept a beat this cycle.
- `x`  in  `WIDTH`  operand X (unsigned; also interpreted as two's complement for the overflow flag).
- `y`  in  `WIDTH`  operand Y.
- `cin`  in  1  carry-in.
- `out_valid`  out  1  result beat present.
- `out_ready`  in  1  consumer accepts the result.
- `s`  out  `WIDTH`  sum, `(x+y+cin) mod 2^WIDTH`.
- `cout`  out  1  carry-out of bit `WIDTH-1`.
- `ovf`  out  1  signed overflow; present only with `PIPELINED_ADDER_OVF_EN`.

## Operation
- Stage k (0..`STAGES-1`) holds:
  - a valid bit;
  - a registered carry;
  - sum chunks 0..k;
  - the still-unused operand chunks k+1..`STAGES-1`.
- Stage 0 adds `x[CHUNK-1:0] + y[CHUNK-1:0] + cin`.
- Stage k>0 adds chunk k of the carried operands plus the carry registered by stage k-1.
- Per-stage ready:
  - `rdy[k] = !valid[k] || rdy[k+1]`, with `rdy[STAGES] = out_ready`.
  - `in_ready = rdy[0]`; this path is combinational.
- A stage loads from its predecessor when `rdy[k]` is high. Its valid bit becomes the predecessor's valid bit (or `in_valid` for stage 0).
- A stage holds its contents when `rdy[k]` is low. Contents of a valid stage never change while stalled.
- The output registers are stage `STAGES-1`: `out_valid = valid[STAGES-1]`, and `s` and `cout` come from that stage.
- Transfer occurs when valid and ready are both high on a rising edge. Beats are never dropped, duplicated or reordered.
- Bubbles collapse: a stalled output does not block upstream stages that are empty.

## Timing
- Reset (asynchronous assert, any time): all valid bits are 0 and all data registers are 0.
  - `out_valid=0`, `s=0`, `cout=0`, `ovf=0`.
  - `in_ready=1` (pipeline empty).
  - Beats in flight are discarded.
  - Release is synchronous to `clk`; the first accept can occur on the first rising edge after deassertion.
- Latency: a beat accepted on edge N appears on `out_*` from edge N+`STAGES`-1. With `STAGES=1` the result is visible in the cycle after acceptance.
- Throughput: one beat per cycle while `out_ready=1`.
- Capacity: `STAGES` beats. With `out_ready=0` and all stages valid, `in_ready=0`.
- Simultaneous accept and drain on a full pipeline: legal. The pipeline advances and occupancy stays at `STAGES`.
- `out_ready` low with `out_valid` low: no effect; the pipeline fills.
- Arithmetic: every carry chain is `CHUNK+1` bits wide, and the top chunk's carry is `cout`.
  - The wrap-around sum `FFFF+0001` is correct even though the carry ripples through every stage.

## Configuration
- `PIPELINED_ADDER_OVF_EN` defined:
  - Port `ovf` exists.
  - `ovf = carry_into_msb XOR cout`, registered in the last stage and aligned with `s`.
  - It resets to 0 and is held under stall like `s`.
- Not defined: port `ovf` and its logic are absent. All other behaviour is identical.

## Test plan
- Reset, then one beat `x=AAAA`, `y=5555`, `cin=0`, `out_ready=1` (16/4) -> `s=FFFF`, `cout=0`, `out_valid` from edge N+3, high for exactly one cycle.
- Carry ripple across all stages: `FFFF+0001`, `cin=0` -> `s=0000`, `cout=1`. Then `FFFF+FFFF`, `cin=1` -> `s=FFFF`, `cout=1`.
- Stream 8 back-to-back beats (including `1234+ABCD`, `cin=0`, and `FEDC+BA98`, `cin=1`) with `out_ready=1` -> results in order, one per cycle: `BE01/c0`, `B975/c1`, etc.
- Backpressure: hold `out_ready=0` while feeding -> `in_ready` falls after 4 accepts and `s`/`out_valid` are stable throughout. Raise `out_ready` -> all 4 results drain in order with no loss.
- Assert `rst_n=0` asynchronously with 3 beats in flight -> `out_valid`, `s` and `cout` go to 0 immediately, and no stale beat emerges after release.
- With `PIPELINED_ADDER_OVF_EN`: `7FFF+0001` -> `s=8000`, `ovf=1`, `cout=0`. `7FFF+8001` -> `s=0000`, `cout=1`, `ovf=0`.
